// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode width and logic-unit opcode encodings.
package alu_pkg;

  localparam int unsigned FUNC_W = 3;

  localparam logic [FUNC_W-1:0] LOGIC_AND   = 3'b000;
  localparam logic [FUNC_W-1:0] LOGIC_OR    = 3'b001;
  localparam logic [FUNC_W-1:0] LOGIC_NAND  = 3'b010;
  localparam logic [FUNC_W-1:0] LOGIC_NOR   = 3'b011;
  localparam logic [FUNC_W-1:0] LOGIC_XOR   = 3'b100;
  localparam logic [FUNC_W-1:0] LOGIC_XNOR  = 3'b101;
  localparam logic [FUNC_W-1:0] LOGIC_NOTA  = 3'b110;
  localparam logic [FUNC_W-1:0] LOGIC_PASSA = 3'b111;

endpackage

// File: rtl/logic_unit_pipe_if.sv
// Operand/result handshake bus of the pipelined logic unit.
//   master: drives A, B, aluFunc, in_valid, out_ready (ALU issue side + consumer)
//   slave : drives in_ready, out_valid, logicOut, zeroFlag, parityFlag (logic unit)
interface logic_unit_pipe_if #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned FUNC_W = 3
);
  logic [WIDTH-1:0]  A;
  logic [WIDTH-1:0]  B;
  logic [FUNC_W-1:0] aluFunc;
  logic              in_valid;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  logicOut;
  logic              zeroFlag;
  logic              parityFlag;

  modport master (
    output A, B, aluFunc, in_valid, out_ready,
    input  in_ready, out_valid, logicOut, zeroFlag, parityFlag
  );

  modport slave (
    input  A, B, aluFunc, in_valid, out_ready,
    output in_ready, out_valid, logicOut, zeroFlag, parityFlag
  );
endinterface

// File: rtl/logic_pipe_stage.sv
// One pipeline slot: valid bit plus result/flag payload with load/hold rule.
//   clk, rst           : clock, async active-low reset
//   i_load             : slot takes the upstream entry this cycle
//   i_valid/i_data/... : upstream entry
//   o_valid/o_data/... : held entry
module logic_pipe_stage #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_zero,
  input  logic             i_par,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_zero,
  output logic             o_par
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic             r_zero;
  logic             r_par;

  // Payload only moves with a valid entry so an emptied output keeps its last value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_zero  <= 1'b0;
      r_par   <= 1'b0;
    end else if (i_load) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_data <= i_data;
        r_zero <= i_zero;
        r_par  <= i_par;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_zero  = r_zero;
  assign o_par   = r_par;

endmodule

// File: rtl/logic_unit_pipe.sv
// Pipelined bitwise logic unit with zero/parity flags and valid/ready flow control.
//   clk  : system clock, rising edge
//   rst  : async active-low reset, discards all in-flight entries
//   busy : at least one pipeline slot holds a valid entry
//   bus  : operand/opcode input and result/flag output handshakes (slave side)
module logic_unit_pipe #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 2,
  parameter int unsigned FUNC_W = alu_pkg::FUNC_W
) (
  input  logic               clk,
  input  logic               rst,
  output logic               busy,
  logic_unit_pipe_if.slave   bus
);

  import alu_pkg::*;

  logic [FUNC_W-1:0] w_func;
  logic [WIDTH-1:0]  w_res;
  logic              w_zero;
  logic              w_par;

  // Index 0 is the input side, index g+1 is the output of slot g.
  logic             w_v [STAGES+1];
  logic [WIDTH-1:0] w_d [STAGES+1];
  logic             w_z [STAGES+1];
  logic             w_p [STAGES+1];
  logic             w_ld [STAGES+1];

  assign w_func = bus.aluFunc;

  // Opcode decode.
  always_comb begin
    w_res = '0;
    case (w_func)
      LOGIC_AND:   w_res = bus.A & bus.B;
      LOGIC_OR:    w_res = bus.A | bus.B;
      LOGIC_NAND:  w_res = ~(bus.A & bus.B);
      LOGIC_NOR:   w_res = ~(bus.A | bus.B);
      LOGIC_XOR:   w_res = bus.A ^ bus.B;
      LOGIC_XNOR:  w_res = ~(bus.A ^ bus.B);
      LOGIC_NOTA:  w_res = ~bus.A;
      LOGIC_PASSA: w_res = bus.A;
      default:     w_res = bus.A;
    endcase
  end

  assign w_zero = (w_res == '0);
  assign w_par  = ^w_res;

  assign w_v[0] = bus.in_valid;
  assign w_d[0] = w_res;
  assign w_z[0] = w_zero;
  assign w_p[0] = w_par;

  // Load chain from the output backwards: a slot loads if empty or if its successor moves.
  always_comb begin
    w_ld[STAGES] = bus.out_ready;
    for (int i = int'(STAGES) - 1; i >= 0; i--) begin
      w_ld[i] = !w_v[i+1] || w_ld[i+1];
    end
  end

  for (genvar g = 0; g < int'(STAGES); g++) begin : g_stage
    logic_pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_ld[g]),
      .i_valid (w_v[g]),
      .i_data  (w_d[g]),
      .i_zero  (w_z[g]),
      .i_par   (w_p[g]),
      .o_valid (w_v[g+1]),
      .o_data  (w_d[g+1]),
      .o_zero  (w_z[g+1]),
      .o_par   (w_p[g+1])
    );
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 1; i <= int'(STAGES); i++) begin
      busy = busy | w_v[i];
    end
  end

  assign bus.in_ready   = w_ld[0];
  assign bus.out_valid  = w_v[STAGES];
  assign bus.logicOut   = w_d[STAGES];
  assign bus.zeroFlag   = w_z[STAGES];
  assign bus.parityFlag = w_p[STAGES];

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench for logic_unit_pipe: three instances (STAGES = 1, 2, 4) driven by the same
// stimulus, each with its own in-order scoreboard of accepted operations.
module tb_logic_unit_pipe;

  localparam int unsigned W = 16;
  localparam int unsigned STG [3] = '{1, 2, 4};

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] a_r, b_r;
  logic [2:0]   f_r;
  logic         iv_r, or_r;

  logic_unit_pipe_if #(.WIDTH(W), .FUNC_W(3)) if1 ();
  logic_unit_pipe_if #(.WIDTH(W), .FUNC_W(3)) if2 ();
  logic_unit_pipe_if #(.WIDTH(W), .FUNC_W(3)) if4 ();

  assign if1.A = a_r; assign if1.B = b_r; assign if1.aluFunc = f_r;
  assign if1.in_valid = iv_r; assign if1.out_ready = or_r;
  assign if2.A = a_r; assign if2.B = b_r; assign if2.aluFunc = f_r;
  assign if2.in_valid = iv_r; assign if2.out_ready = or_r;
  assign if4.A = a_r; assign if4.B = b_r; assign if4.aluFunc = f_r;
  assign if4.in_valid = iv_r; assign if4.out_ready = or_r;

  logic busy1, busy2, busy4;

  logic_unit_pipe #(.WIDTH(W), .STAGES(1), .FUNC_W(3)) dut1 (.clk(clk), .rst(rst), .busy(busy1), .bus(if1));
  logic_unit_pipe #(.WIDTH(W), .STAGES(2), .FUNC_W(3)) dut2 (.clk(clk), .rst(rst), .busy(busy2), .bus(if2));
  logic_unit_pipe #(.WIDTH(W), .STAGES(4), .FUNC_W(3)) dut4 (.clk(clk), .rst(rst), .busy(busy4), .bus(if4));

  logic         rdy [3], ov [3], zf [3], pf [3], bz [3];
  logic [W-1:0] lo [3];
  assign rdy[0] = if1.in_ready; assign ov[0] = if1.out_valid; assign lo[0] = if1.logicOut;
  assign zf[0]  = if1.zeroFlag; assign pf[0] = if1.parityFlag; assign bz[0] = busy1;
  assign rdy[1] = if2.in_ready; assign ov[1] = if2.out_valid; assign lo[1] = if2.logicOut;
  assign zf[1]  = if2.zeroFlag; assign pf[1] = if2.parityFlag; assign bz[1] = busy2;
  assign rdy[2] = if4.in_ready; assign ov[2] = if4.out_valid; assign lo[2] = if4.logicOut;
  assign zf[2]  = if4.zeroFlag; assign pf[2] = if4.parityFlag; assign bz[2] = busy4;

  // Reference model state: FIFO of expected {zero, parity, result} plus accept cycle.
  logic [W+1:0] qmem  [3][64];
  int           stamp [3][64];
  int           qhead [3];
  int           qtail [3];
  int           cyc;
  bit           lat_chk;
  int           passed;
  int           total;

  function automatic logic [W+1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [2:0] f);
    logic [W-1:0] r;
    logic         z, p;
    case (f)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: r = ~(a & b);
      3'd3: r = ~(a | b);
      3'd4: r = a ^ b;
      3'd5: r = ~(a ^ b);
      3'd6: r = ~a;
      default: r = a;
    endcase
    z = (r == 16'h0000);
    p = (($countones(r) % 2) == 1);
    return {z, p, r};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One clock: compare against the model just before the rising edge, then advance.
  task automatic cycle();
    #1;
    for (int d = 0; d < 3; d++) begin
      int           cnt;
      logic [W+1:0] e;
      cnt = qtail[d] - qhead[d];
      check($sformatf("in_ready_s%0d", STG[d]), 32'(rdy[d]),
            32'((cnt < int'(STG[d])) || or_r));
      check($sformatf("busy_s%0d", STG[d]), 32'(bz[d]), 32'(cnt > 0));
      if (ov[d]) begin
        if (cnt == 0) begin
          check($sformatf("stale_out_valid_s%0d", STG[d]), 32'(ov[d]), 32'd0);
        end else begin
          e = qmem[d][qhead[d] % 64];
          check($sformatf("logicOut_s%0d", STG[d]), 32'(lo[d]), 32'(e[W-1:0]));
          check($sformatf("zeroFlag_s%0d", STG[d]), 32'(zf[d]), 32'(e[W+1]));
          check($sformatf("parityFlag_s%0d", STG[d]), 32'(pf[d]), 32'(e[W]));
          if (or_r) begin
            if (lat_chk)
              check($sformatf("latency_s%0d", STG[d]),
                    32'(cyc - stamp[d][qhead[d] % 64]), 32'(STG[d]));
            qhead[d] = qhead[d] + 1;
          end
        end
      end
      if (iv_r && rdy[d]) begin
        qmem[d][qtail[d] % 64]  = ref_op(a_r, b_r, f_r);
        stamp[d][qtail[d] % 64] = cyc;
        qtail[d] = qtail[d] + 1;
      end
    end
    @(posedge clk);
    cyc = cyc + 1;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    iv_r = 1'b0;
    for (int k = 0; k < n; k++) begin
      f_r = 3'($urandom);
      a_r = 16'($urandom);
      cycle();
    end
  endtask

  task automatic issue_rand();
    a_r = 16'($urandom); b_r = 16'($urandom); f_r = 3'($urandom); iv_r = 1'b1;
    cycle();
  endtask

  initial begin
    passed = 0; total = 0; cyc = 0; lat_chk = 1'b1;
    for (int d = 0; d < 3; d++) begin qhead[d] = 0; qtail[d] = 0; end
    a_r = '0; b_r = '0; f_r = '0; iv_r = 1'b0; or_r = 1'b1;

    // Reset values
    @(negedge clk); @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check("rst_out_valid", 32'(ov[d]), 32'd0);
      check("rst_logicOut",  32'(lo[d]), 32'd0);
      check("rst_zeroFlag",  32'(zf[d]), 32'd0);
      check("rst_parity",    32'(pf[d]), 32'd0);
      check("rst_busy",      32'(bz[d]), 32'd0);
    end
    rst = 1'b1;

    // Back-to-back stream of all opcodes
    for (int op = 0; op < 8; op++) begin
      a_r = 16'hF0F0; b_r = 16'h0FF0; f_r = 3'(op); iv_r = 1'b1;
      cycle();
    end
    idle(6);

    // Flag corner cases
    a_r = 16'h00FF; b_r = 16'hFF00; f_r = 3'd0; iv_r = 1'b1; cycle();
    f_r = 3'd4; cycle();
    a_r = 16'h0001; f_r = 3'd7; cycle();
    idle(6);

    // Backpressure: fill, hold frozen, then drain
    lat_chk = 1'b0;
    or_r = 1'b0;
    for (int k = 0; k < 4; k++) issue_rand();
    idle(3);
    or_r = 1'b1;
    idle(8);
    lat_chk = 1'b1;

    // Continuous full-throughput streaming
    for (int k = 0; k < 20; k++) issue_rand();
    idle(6);

    // Random valid/ready mix
    lat_chk = 1'b0;
    for (int k = 0; k < 60; k++) begin
      a_r = 16'($urandom); b_r = 16'($urandom); f_r = 3'($urandom);
      iv_r = 1'($urandom); or_r = 1'($urandom);
      cycle();
    end
    or_r = 1'b1;
    idle(8);
    lat_chk = 1'b1;

    // Asynchronous reset with entries in flight
    or_r = 1'b0;
    issue_rand();
    issue_rand();
    iv_r = 1'b0;
    rst = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      check("midrst_out_valid", 32'(ov[d]), 32'd0);
      check("midrst_busy",      32'(bz[d]), 32'd0);
      check("midrst_logicOut",  32'(lo[d]), 32'd0);
      qhead[d] = qtail[d];
    end
    @(negedge clk);
    rst = 1'b1;
    or_r = 1'b1;
    idle(2);
    for (int op = 0; op < 8; op++) begin
      a_r = 16'hF0F0; b_r = 16'h0FF0; f_r = 3'(op); iv_r = 1'b1;
      cycle();
    end
    idle(6);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
Parametrised, pipelined successor to the single-cycle ALU logic unit. It adds an extended opcode set, result flags, and a valid/ready handshake with backpressure. The block sits in the ALU beside the arithmetic, shift and compare units, and it feeds the ALU output mux and the register-file writeback. Pipeline depth is configurable so the block can be balanced against the arithmetic unit's latency.

Parameters:
WIDTH, 16, operand and result width in bits (≥2)
STAGES, 2, number of register stages from input to output (1..4)
FUNC_W, 3, opcode width (fixed at 3; parameter exists for package consistency)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
A  input  WIDTH  operand A
B  input  WIDTH  operand B
aluFunc  input  FUNC_W  opcode
in_valid  input  1  operands and opcode valid this cycle
in_ready  output  1  block can accept an operation this cycle
out_valid  output  1  logicOut and flags valid
out_ready  input  1  downstream consumes the result this cycle
logicOut  output  WIDTH  result
zeroFlag  output  1  logicOut == 0
parityFlag  output  1  XOR-reduction of logicOut
busy  output  1  at least one stage holds a valid entry

Behaviour:
- Clock and reset: single clock clk. Reset rst is asynchronous, active-low.
- Reset values: all stage valid bits 0 and all stage data 0. Therefore out_valid=0, logicOut=0, zeroFlag=0, parityFlag=0, busy=0. in_ready=1 in the first cycle after reset deasserts.
- Opcodes:
  - 000 A&B
  - 001 A|B
  - 010 ~(A&B)
  - 011 ~(A|B)
  - 100 A^B
  - 101 ~(A^B)
  - 110 ~A
  - 111 pass A
- Flag timing: result and flags are computed combinationally at the input and captured into stage 0. Flags travel with the data.
- Stages: each stage i holds {valid_i, data_i, zero_i, par_i}. The last stage drives the outputs.
- Stage advance rule: stage i loads from stage i-1 (or from the input when i=0) when (!valid_i) or (stage i+1 advances). For the last stage, "advances" means out_valid && out_ready.
- Stage valid update: when stage i loads, valid_i takes the upstream valid. When stage i does not load, it holds.
- Handshake:
  - in_ready = stage-0 load condition.
  - A transfer occurs on in_valid && in_ready.
  - Operands are not captured without in_ready.
- Latency: with no backpressure, a result appears STAGES cycles after acceptance. Throughput is 1 operation per cycle.
- Backpressure:
  - While out_valid && !out_ready, logicOut and the flags hold stable.
  - Stages fill from the output backwards. in_ready drops only when every stage is valid.
- Full pipeline with out_ready=1: accept and emit happen in the same cycle with no bubble.
- Empty pipeline: out_valid=0. logicOut keeps its last value. Downstream logic must not sample it.
- STAGES=1: one register. in_ready = !out_valid || out_ready.
- aluFunc change while in_valid is low: no effect.
- Reset asserted mid-operation: all in-flight entries are discarded immediately. No partial result is emitted.
- busy = OR of all valid_i.
- Width rules: all operations are bitwise at WIDTH. No carry, no overflow, no sign handling.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams LOGIC_AND, LOGIC_OR, LOGIC_NAND, LOGIC_NOR, LOGIC_XOR, LOGIC_XNOR, LOGIC_NOTA, LOGIC_PASSA
  - FUNC_W
- Sub-module logic_pipe_stage (parameter WIDTH):
  - one valid/data/flag register with the load/hold rule
  - instantiated STAGES times in a generate loop
- Top level holds the opcode decode, the flag computation and the in_ready chain.

Test Plan:
- Reset, then stream 8 ops (STAGES=2, out_ready=1) with A=16'hF0F0 and B=16'h0FF0 across opcodes 000..111 -> outputs in order with no bubbles, each 2 cycles after acceptance: 00F0, FFF0, FF0F, 000F, FF00, 00FF, 0F0F, F0F0.
- A=16'h00FF, B=16'hFF00, op 000 -> logicOut=0000, zeroFlag=1, parityFlag=0. Then op 100 -> FFFF, zeroFlag=0, parityFlag=0. Then A=16'h0001, op 111 -> parityFlag=1.
- Hold out_ready=0 while streaming 4 ops -> in_ready falls after exactly STAGES accepts, and the outputs stay frozen. Raise out_ready -> all results drain in order with none lost or duplicated.
- Full pipeline, out_ready=1, in_valid=1 continuously for 20 cycles -> in_ready stays 1 and exactly one result is emitted per cycle.
- Pull rst low with 2 entries in flight -> out_valid, busy and logicOut drop to 0 immediately (before the next clock edge). After release, in_ready=1 and no stale result appears.
- Re-run the first scenario with STAGES=1 and STAGES=4 -> latency 1 and 4 respectively, with identical results.
